// File: rtl/w_ser_pkg.sv
// rtl/w_ser_pkg.sv - shared state type and default sizing for the w pattern serializer
package w_ser_pkg;

   localparam int W_SER_MAX_LEN = 16;
   localparam int W_SER_GAP_W   = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } w_ser_state_t;

endpackage

// File: rtl/w_ser_shreg.sv
// rtl/w_ser_shreg.sv - loadable left-shift register presenting pattern bit len-1 first
module w_ser_shreg
   import w_ser_pkg::*;
#(
   parameter int MAX_LEN = W_SER_MAX_LEN,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_i,
   input  logic               shift_i,
   input  logic [MAX_LEN-1:0] pattern_i,
   input  logic [LEN_W-1:0]   len_i,
   output logic               msb_o
);

   logic [MAX_LEN-1:0] data_q;
   logic [LEN_W-1:0]   pad;

   // len_i is already clamped, so the pad never underflows; len 0 loads all zeros.
   assign pad = LEN_W'(MAX_LEN) - len_i;

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= '0;
      end else if (load_i) begin
         data_q <= pattern_i << pad;
      end else if (shift_i) begin
         data_q <= {data_q[MAX_LEN-2:0], 1'b0};
      end
   end

   assign msb_o = data_q[MAX_LEN-1];

endmodule

// File: rtl/w_pattern_serializer.sv
// rtl/w_pattern_serializer.sv - sends a captured pattern MSB-first on w, then idles for gap cycles
module w_pattern_serializer
   import w_ser_pkg::*;
#(
   parameter int MAX_LEN = W_SER_MAX_LEN,
   parameter int GAP_W   = W_SER_GAP_W,
   localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [MAX_LEN-1:0] in_pattern,
   input  logic [LEN_W-1:0]   in_len,
   input  logic [GAP_W-1:0]   in_gap,
   output logic               w,
   output logic               w_valid,
   output logic               last,
   output logic               done,
   output logic               busy
);

   w_ser_state_t     state_q;
   logic [LEN_W-1:0] bit_cnt_q;
   logic [GAP_W-1:0] gap_cnt_q;
   logic             in_ready_q;
   logic             w_valid_q;
   logic             last_q;
   logic             done_q;

   logic [LEN_W-1:0] len_c;
   logic             accept;
   logic             shift_en;

   assign len_c    = (in_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : in_len;
   assign accept   = in_valid && in_ready_q;
   assign shift_en = (state_q == SHIFT);

   w_ser_shreg #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_shreg (
      .clk       (clk),
      .reset     (reset),
      .load_i    (accept),
      .shift_i   (shift_en),
      .pattern_i (in_pattern),
      .len_i     (len_c),
      .msb_o     (w)
   );

   // The gap count is captured on accept and simply held while the bits shift out.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         gap_cnt_q  <= '0;
         in_ready_q <= 1'b1;
         w_valid_q  <= 1'b0;
         last_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  gap_cnt_q <= in_gap;
                  bit_cnt_q <= len_c;
                  if (len_c != '0) begin
                     state_q    <= SHIFT;
                     in_ready_q <= 1'b0;
                     w_valid_q  <= 1'b1;
                     last_q     <= (len_c == LEN_W'(1));
                  end else if (in_gap != '0) begin
                     state_q    <= GAP;
                     in_ready_q <= 1'b0;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               if (bit_cnt_q <= LEN_W'(1)) begin
                  bit_cnt_q <= '0;
                  w_valid_q <= 1'b0;
                  last_q    <= 1'b0;
                  if (gap_cnt_q != '0) begin
                     state_q <= GAP;
                  end else begin
                     state_q    <= IDLE;
                     in_ready_q <= 1'b1;
                     done_q     <= 1'b1;
                  end
               end else begin
                  bit_cnt_q <= bit_cnt_q - LEN_W'(1);
                  last_q    <= (bit_cnt_q == LEN_W'(2));
               end
            end
            GAP: begin
               if (gap_cnt_q <= GAP_W'(1)) begin
                  gap_cnt_q  <= '0;
                  state_q    <= IDLE;
                  in_ready_q <= 1'b1;
                  done_q     <= 1'b1;
               end else begin
                  gap_cnt_q <= gap_cnt_q - GAP_W'(1);
               end
            end
            default: begin
               state_q    <= IDLE;
               in_ready_q <= 1'b1;
               w_valid_q  <= 1'b0;
               last_q     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready = in_ready_q;
   assign busy     = !in_ready_q;
   assign w_valid  = w_valid_q;
   assign last     = last_q;
   assign done     = done_q;

endmodule

// File: tb/tb_w_pattern_serializer.sv
// tb/tb_w_pattern_serializer.sv - directed bench for w_pattern_serializer with a 1101 detector on w
module tb_w_pattern_serializer;

   localparam int MAX_LEN = 16;
   localparam int GAP_W   = 4;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);

   logic               clk = 1'b0;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic [MAX_LEN-1:0] in_pattern;
   logic [LEN_W-1:0]   in_len;
   logic [GAP_W-1:0]   in_gap;
   logic               w;
   logic               w_valid;
   logic               last;
   logic               done;
   logic               busy;

   int total = 0;
   int bad   = 0;

   logic [3:0] hist_q;
   logic       z;

   w_pattern_serializer #(
      .MAX_LEN (MAX_LEN),
      .GAP_W   (GAP_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_pattern (in_pattern),
      .in_len     (in_len),
      .in_gap     (in_gap),
      .w          (w),
      .w_valid    (w_valid),
      .last       (last),
      .done       (done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Sequence detector sampling w each clock; z is high while the last four bits were 1101.
   always_ff @(posedge clk) begin
      if (reset) hist_q <= 4'b0000;
      else       hist_q <= {hist_q[2:0], w};
   end
   assign z = (hist_q == 4'b1101);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [4:0]  exp_w5;
      logic [2:0]  exp_w3;
      logic [15:0] exp_w16;
      logic [7:0]  exp_w8;
      logic [5:0]  exp_z;
      logic        saw_done;

      reset      = 1'b1;
      in_valid   = 1'b0;
      in_pattern = '0;
      in_len     = '0;
      in_gap     = '0;

      repeat (3) step();
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_w",        32'(w),        32'd0);
      chk("reset_w_valid",  32'(w_valid),  32'd0);
      chk("reset_last",     32'(last),     32'd0);
      chk("reset_done",     32'(done),     32'd0);
      chk("reset_busy",     32'(busy),     32'd0);
      reset = 1'b0;
      step();

      // Single pattern 11011, len 5, gap 2
      exp_w5     = 5'b11011;
      in_pattern = 16'h001B;
      in_len     = 5'd5;
      in_gap     = 4'd2;
      in_valid   = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("single_w",       32'(w),       32'(exp_w5[4-i]));
         chk("single_w_valid", 32'(w_valid), 32'd1);
         chk("single_last",    32'(last),    (i == 4) ? 32'd1 : 32'd0);
         chk("single_busy",    32'(busy),    32'd1);
         step();
      end
      for (int i = 0; i < 2; i++) begin
         chk("single_gap_w",       32'(w),       32'd0);
         chk("single_gap_w_valid", 32'(w_valid), 32'd0);
         chk("single_gap_done",    32'(done),    32'd0);
         step();
      end
      chk("single_done",     32'(done),     32'd1);
      chk("single_in_ready", 32'(in_ready), 32'd1);
      step();
      chk("single_done_one_cycle", 32'(done), 32'd0);

      // Back-to-back: 101 (len 3, gap 0) then len 20 clamped to 16, gap 1; in_valid held high
      exp_w3     = 3'b101;
      in_pattern = 16'hFFF5;
      in_len     = 5'd3;
      in_gap     = 4'd0;
      in_valid   = 1'b1;
      step();
      in_pattern = 16'hA5C3;
      in_len     = 5'd20;
      in_gap     = 4'd1;
      for (int i = 0; i < 3; i++) begin
         chk("b2b_first_w",     32'(w),        32'(exp_w3[2-i]));
         chk("b2b_first_ready", 32'(in_ready), 32'd0);
         chk("b2b_first_last",  32'(last),     (i == 2) ? 32'd1 : 32'd0);
         step();
      end
      chk("b2b_first_done",  32'(done),     32'd1);
      chk("b2b_done_ready",  32'(in_ready), 32'd1);
      chk("b2b_done_wvalid", 32'(w_valid),  32'd0);
      step();
      in_valid = 1'b0;
      exp_w16  = 16'hA5C3;
      for (int i = 0; i < 16; i++) begin
         chk("clamp_w",       32'(w),       32'(exp_w16[15-i]));
         chk("clamp_w_valid", 32'(w_valid), 32'd1);
         chk("clamp_last",    32'(last),    (i == 15) ? 32'd1 : 32'd0);
         step();
      end
      chk("clamp_gap_w_valid", 32'(w_valid), 32'd0);
      chk("clamp_gap_done",    32'(done),    32'd0);
      step();
      chk("clamp_done", 32'(done), 32'd1);
      step();

      // Zero length, zero gap: done one cycle after accept
      in_len   = 5'd0;
      in_gap   = 4'd0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("zero_done",    32'(done),     32'd1);
      chk("zero_wvalid",  32'(w_valid),  32'd0);
      chk("zero_ready",   32'(in_ready), 32'd1);
      step();
      chk("zero_done_clr", 32'(done), 32'd0);

      // Zero length, gap 3: done at k+4
      in_gap   = 4'd3;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("zgap_busy",   32'(busy),    32'd1);
         chk("zgap_wvalid", 32'(w_valid), 32'd0);
         chk("zgap_done",   32'(done),    32'd0);
         step();
      end
      chk("zgap_done_k4", 32'(done), 32'd1);
      step();

      // Single-bit pattern: first bit is also last
      in_pattern = 16'h0001;
      in_len     = 5'd1;
      in_gap     = 4'd0;
      in_valid   = 1'b1;
      step();
      in_valid = 1'b0;
      chk("len1_w",    32'(w),    32'd1);
      chk("len1_last", 32'(last), 32'd1);
      step();
      chk("len1_done", 32'(done), 32'd1);
      chk("len1_w_after", 32'(w), 32'd0);
      step();

      // Reset during bit 3 of an 8-bit pattern
      exp_w8     = 8'b10110011;
      in_pattern = 16'h00B3;
      in_len     = 5'd8;
      in_gap     = 4'd2;
      in_valid   = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("rst_mid_w", 32'(w), 32'(exp_w8[7-i]));
         if (i < 2) step();
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_mid_wvalid", 32'(w_valid),  32'd0);
      chk("rst_mid_ready",  32'(in_ready), 32'd1);
      chk("rst_mid_w0",     32'(w),        32'd0);
      chk("rst_mid_busy",   32'(busy),     32'd0);
      saw_done = 1'b0;
      for (int i = 0; i < 16; i++) begin
         saw_done = saw_done | done;
         step();
      end
      chk("rst_mid_no_done", 32'(saw_done), 32'd0);

      // Detector pairing: 1101, len 4, gap 1
      exp_z      = 6'b000010;
      in_pattern = 16'h000D;
      in_len     = 5'd4;
      in_gap     = 4'd1;
      in_valid   = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("det_z", 32'(z), 32'(exp_z[5-i]));
         chk("det_done", 32'(done), (i == 5) ? 32'd1 : 32'd0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/w_pattern_serializer.md
# w_pattern_serializer

Stimulus transmitter for the serial-bit `w` interface consumed by the q2fsm-style sequence detectors. It accepts a parallel bit pattern, its length and an inter-pattern gap through a valid/ready handshake. It then drives the pattern MSB-first onto `w`, one bit per clock, followed by the requested number of idle-zero cycles. It sits between bench or firmware stimulus logic and any detector that samples `w` on `clk`.

## Interface
- `MAX_LEN`, default 16: maximum pattern length in bits; must be ≥ 2.
- `GAP_W`, default 4: width of the gap-count field.
- `LEN_W`, derived as `$clog2(MAX_LEN+1)`: width of `in_len`; not overridable.

Ports:
- `clk`  in  1  Clock.
- `reset`  in  1  Synchronous, active-high reset.
- `in_valid`  in  1  Pattern request.
- `in_ready`  out  1  Block can accept a pattern.
- `in_pattern`  in  MAX_LEN  Pattern bits; the transmitted window is `[in_len-1:0]`.
- `in_len`  in  LEN_W  Number of bits to send; 0 is legal.
- `in_gap`  in  GAP_W  Idle cycles after the last bit.
- `w`  out  1  Serial data to the detector.
- `w_valid`  out  1  `w` carries a pattern bit this cycle.
- `last`  out  1  Final bit of the current pattern.
- `done`  out  1  One-cycle pulse when a request completes.
- `busy`  out  1  Request in progress; equals `!in_ready`.

## Operation
- **States:** IDLE, SHIFT, GAP.
- **Reset values:** state IDLE; `in_ready`=1; `w`, `w_valid`, `last`, `done`, `busy` = 0.
- **Accept:** occurs when `in_valid && in_ready`. `in_ready` is high only in IDLE.
- **Captured on accept:** the pattern window, `in_len` and `in_gap`.
- **Length clamp:** `in_len > MAX_LEN` is clamped to `MAX_LEN`.
- **Transitions:**
  - IDLE → SHIFT on accept with len ≥ 1.
  - IDLE → GAP on accept with len = 0 and gap ≥ 1.
  - IDLE → IDLE on accept with len = 0 and gap = 0; `done` is still produced next cycle.
  - SHIFT → GAP after the last bit when gap ≥ 1; SHIFT → IDLE after the last bit when gap = 0.
  - GAP → IDLE when the gap counter reaches zero.
- **SHIFT outputs:**
  - `w` = the current MSB of the shift register; the first bit is `in_pattern[len-1]`.
  - `w_valid` = 1.
  - `last` = 1 only when the remaining-bit count is 1.
- **GAP and IDLE outputs:** `w`=0, `w_valid`=0, `last`=0.
- **Done:**
  - `done` is registered. It pulses for exactly one cycle on the first IDLE cycle following completion.
  - In that cycle `in_ready`=1, so a new accept may coincide with `done`.
- **Input stability:** while `busy`, inputs are ignored and input changes have no effect.
- **Reset mid-operation:** the pattern is discarded and state returns to IDLE on the next edge. No `done` is issued for the aborted request.
- **Counters:** the bit counter is LEN_W wide and counts down from len. The gap counter is GAP_W wide and counts down from gap. Neither wraps; both stop at 0.

## Timing
Accept at cycle k, with L = clamped len and G = gap:
- Cycles k+1 … k+L: bits on `w`, `w_valid`=1; `last`=1 in cycle k+L only.
- Cycles k+L+1 … k+L+G: `w`=0, `w_valid`=0.
- Cycle k+L+G+1: IDLE, `in_ready`=1, `done`=1.
- Back-to-back patterns: throughput is L+G+1 cycles per request, with no extra bubble beyond the `done` cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- **Shared package `w_ser_pkg`:**
  - State enum typedef `w_ser_state_t` {IDLE, SHIFT, GAP}.
  - Default `MAX_LEN` and `GAP_W` constants.
- **Sub-module `w_ser_shreg`:**
  - Loadable MAX_LEN-wide left-shift register.
  - Load aligns `in_pattern[len-1]` to its MSB and zero-fills below.
  - Exposes the MSB.
- The top level holds the FSM, both counters and the handshake.

## Test plan
- **Reset:** reset held 3 cycles → `in_ready`=1, `w`=0, `w_valid`=0, `done`=0.
- **Single pattern:** pattern=5'b11011, len=5, gap=2 → `w` = 1,1,0,1,1 in cycles k+1…k+5; `last` at k+5; `w`=0 at k+6 and k+7; `done` at k+8.
- **Back-to-back with clamp:**
  - `in_valid` held high; first request len=3 pattern 3'b101, gap=0.
  - Second request presented while `in_ready` is low is not accepted until the `done` cycle.
  - Second request len=20 with MAX_LEN=16 sends 16 bits.
- **Zero length:** len=0, gap=0 → no `w_valid`; `done` one cycle after accept. len=0, gap=3 → `done` at k+4.
- **Reset mid-shift:** reset at bit 3 of an 8-bit pattern → IDLE next cycle, `w_valid`=0, and no `done` pulse ever for that request.
- **Detector pairing:** `w` drives the q2fsm detector with pattern 4'b1101, len=4, gap=1 → detector z sequence matches its golden model, checked cycle by cycle.
